// File: rtl/sram_link_initiator_if.sv
// Host-request, response and byte-link signals of the SRAM link initiator.
// The master modport is the initiator's view; slave is the host/controller side.
interface sram_link_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        link_tx_valid;
  logic        link_tx_ready;
  logic [7:0]  link_tx_data;
  logic        link_rx_valid;
  logic        link_rx_ready;
  logic [7:0]  link_rx_data;
  logic        busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  link_tx_ready, link_rx_valid, link_rx_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output link_tx_valid, link_tx_data, link_rx_ready, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output link_tx_ready, link_rx_valid, link_rx_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  link_tx_valid, link_tx_data, link_rx_ready, busy
  );
endinterface

// File: rtl/sram_link_initiator.sv
// Serialises one 32-bit SRAM read/write into command + data bytes and reassembles read returns.
// Optional read-return timeout abort is enabled by defining RSP_TIMEOUT_EN.
module sram_link_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_link_initiator_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  tx_byte;

`ifdef RSP_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic        err_q, err_d;
  logic [15:0] tmo_q, tmo_d;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
`ifdef RSP_TIMEOUT_EN
    err_d   = err_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_CMD;
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMD: begin
        if (bus.link_tx_ready) begin
          // Previous response data stays visible until this point.
          cnt_d   = 2'd0;
          rdata_d = 32'h0000_0000;
          state_d = write_q ? S_WDATA : S_RD_WAIT;
`ifdef RSP_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
        end else begin
          state_d = S_CMD;
        end
      end
      S_WDATA: begin
        if (bus.link_tx_ready) begin
          if (cnt_q == 2'd3) begin
            state_d = S_RESP;
            rdata_d = 32'h0000_0000;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RD_WAIT: begin
        if (bus.link_rx_valid) begin
          case (cnt_q)
            2'd0:    rdata_d[7:0]   = bus.link_rx_data;
            2'd1:    rdata_d[15:8]  = bus.link_rx_data;
            2'd2:    rdata_d[23:16] = bus.link_rx_data;
            2'd3:    rdata_d[31:24] = bus.link_rx_data;
            default: rdata_d        = rdata_q;
          endcase
          if (cnt_q == 2'd3) begin
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
`ifdef RSP_TIMEOUT_EN
          tmo_d = 16'd0;
`endif
        end else begin
`ifdef RSP_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
`else
          state_d = S_RD_WAIT;
`endif
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
`ifdef RSP_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      cnt_q   <= 2'd0;
`ifdef RSP_TIMEOUT_EN
      err_q   <= 1'b0;
      tmo_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
`ifdef RSP_TIMEOUT_EN
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Outgoing byte: command byte (bit 5 set for reads), then write data MSB first
  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      S_CMD: tx_byte = {2'b00, ~write_q, addr_q};
      S_WDATA: begin
        case (cnt_q)
          2'd0:    tx_byte = wdata_q[31:24];
          2'd1:    tx_byte = wdata_q[23:16];
          2'd2:    tx_byte = wdata_q[15:8];
          2'd3:    tx_byte = wdata_q[7:0];
          default: tx_byte = 8'h00;
        endcase
      end
      default: tx_byte = 8'h00;
    endcase
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.link_tx_valid = (state_q == S_CMD) || (state_q == S_WDATA);
  assign bus.link_tx_data  = tx_byte;
  assign bus.link_rx_ready = (state_q == S_RD_WAIT);
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_rdata     = rdata_q;
`ifdef RSP_TIMEOUT_EN
  assign bus.rsp_err       = err_q;
`else
  assign bus.rsp_err       = 1'b0;
`endif

endmodule
